// File: rtl/sram_mem_stage_if.sv
// Pipeline-side request/response bundle between the execute stage and sram_mem_stage.
interface sram_mem_stage_if;
  logic        MEM_R_en;
  logic        MEM_W_en;
  logic [31:0] address;
  logic [31:0] Val_Rm;
  logic [31:0] mem_read_data;
  logic        ready;

  modport master (
    output MEM_R_en, MEM_W_en, address, Val_Rm,
    input  mem_read_data, ready
  );

  modport slave (
    input  MEM_R_en, MEM_W_en, address, Val_Rm,
    output mem_read_data, ready
  );
endinterface

// File: rtl/sram_mem_stage.sv
// Memory-stage SRAM controller: 32-bit loads/stores as two 16-bit half-word accesses.
// Optional one-entry last-word read cache enabled by macro SRAM_LAST_WORD_CACHE_EN.
module sram_mem_stage #(
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  sram_mem_stage_if.slave    bus,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               is_wr_q, is_wr_d;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               req;
  logic               last_beat;
  logic [31:0]        offset;
  logic [SRAM_AW-2:0] req_word;
  logic               unused_addr_bits;
  logic               hit;
  logic [31:0]        hit_data;
  logic               drive_dq;
  logic [15:0]        dq_out;

  assign req       = bus.MEM_R_en | bus.MEM_W_en;
  assign last_beat = (cnt_q == 3'(WAIT_CYCLES));

  // Below-base addresses wrap through the unsigned subtraction; upper bits are dropped.
  assign offset           = bus.address - 32'(ADDR_BASE);
  assign req_word         = offset[SRAM_AW:2];
  assign unused_addr_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

`ifdef SRAM_LAST_WORD_CACHE_EN
  logic               c_valid_q, c_valid_d;
  logic [SRAM_AW-2:0] c_tag_q, c_tag_d;
  logic [31:0]        c_data_q, c_data_d;

  assign hit      = c_valid_q && bus.MEM_R_en && !bus.MEM_W_en && (c_tag_q == req_word);
  assign hit_data = c_data_q;

  always_comb begin
    c_valid_d = c_valid_q;
    c_tag_d   = c_tag_q;
    c_data_d  = c_data_q;
    if (state_q == S_DONE) begin
      if (!is_wr_q) begin
        c_valid_d = 1'b1;
        c_tag_d   = word_q;
        c_data_d  = rdata_q;
      end else if (c_valid_q && (c_tag_q == word_q)) begin
        c_data_d  = wdata_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_valid_q <= 1'b0;
      c_tag_q   <= '0;
      c_data_q  <= '0;
    end else begin
      c_valid_q <= c_valid_d;
      c_tag_q   <= c_tag_d;
      c_data_q  <= c_data_d;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          rdata_d = hit_data;
        end else if (req) begin
          state_d = S_LOW;
          cnt_d   = '0;
          is_wr_d = bus.MEM_W_en;
          word_d  = req_word;
          wdata_d = bus.Val_Rm;
        end
      end
      S_LOW: begin
        if (last_beat) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          if (!is_wr_q) rdata_d[15:0] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_HIGH: begin
        if (last_beat) begin
          state_d = S_DONE;
          cnt_d   = '0;
          if (!is_wr_q) rdata_d[31:16] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign drive_dq  = is_wr_q && ((state_q == S_LOW) || (state_q == S_HIGH));
  assign dq_out    = (state_q == S_LOW) ? wdata_q[15:0] : wdata_q[31:16];
  assign SRAM_WE_N = !drive_dq;
  assign SRAM_DQ   = drive_dq ? dq_out : 'z;

  always_comb begin
    SRAM_ADDR = '0;
    if (state_q == S_LOW)  SRAM_ADDR = {word_q, 1'b0};
    if (state_q == S_HIGH) SRAM_ADDR = {word_q, 1'b1};
  end

  // A cache hit bypasses the register so the pipeline sees the data in the same cycle.
  assign bus.ready         = ((state_q == S_IDLE) && (!req || hit)) || (state_q == S_DONE);
  assign bus.mem_read_data = ((state_q == S_IDLE) && hit) ? hit_data : rdata_q;

endmodule

// File: tb/tb_sram_mem_stage.sv
// Directed self-checking bench for sram_mem_stage with a behavioural 16-bit SRAM model.
module tb_sram_mem_stage;

  logic        clk;
  logic        rst;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N;
  logic [15:0] sram [0:255];

  int unsigned checks;
  int unsigned errors;

  sram_mem_stage_if bus();

  sram_mem_stage #(
    .ADDR_BASE   (1024),
    .WAIT_CYCLES (1),
    .SRAM_AW     (18)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_WE_N (SRAM_WE_N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM drives the bus whenever it is not being written.
  assign SRAM_DQ = SRAM_WE_N ? sram[SRAM_ADDR[7:0]] : 'z;
  always @(posedge clk) if (!SRAM_WE_N) sram[SRAM_ADDR[7:0]] <= SRAM_DQ;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.MEM_R_en = 1'b0;
    bus.MEM_W_en = 1'b0;
    bus.address  = '0;
    bus.Val_Rm   = '0;
  endtask

  // Entered #1 after a negedge with the DUT in IDLE; returns in the IDLE after DONE.
  task automatic access(input bit w, input bit r, input logic [31:0] addr,
                        input logic [31:0] val, input logic [17:0] lo,
                        input logic [31:0] exp_rd);
    logic [17:0] hi;
    hi = lo | 18'd1;
    bus.MEM_W_en = w;
    bus.MEM_R_en = r;
    bus.address  = addr;
    bus.Val_Rm   = val;
    #1;
    chk("req_ready_low", bus.ready, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk("busy_ready", bus.ready, 0);
      chk("sram_addr", SRAM_ADDR, (c < 2) ? lo : hi);
      chk("we_n", SRAM_WE_N, w ? 0 : 1);
      if (w) begin
        chk("dq_write", SRAM_DQ, (c < 2) ? val[15:0] : val[31:16]);
        chk("rdata_held_wr", bus.mem_read_data, exp_rd);
      end
    end
    @(negedge clk); #1;
    chk("done_ready", bus.ready, 1);
    chk("done_we_n", SRAM_WE_N, 1);
    chk("done_rdata", bus.mem_read_data, exp_rd);
    idle_inputs();
    @(negedge clk); #1;
    chk("idle_ready", bus.ready, 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) sram[i] = 16'h0000;
    sram[0] = 16'hA5A5;
    sram[8] = 16'h3344;
    sram[9] = 16'h1122;
    idle_inputs();
    rst = 1'b0;

    @(negedge clk); #1;
    chk("rst_ready", bus.ready, 1);
    chk("rst_we_n", SRAM_WE_N, 1);
    chk("rst_addr", SRAM_ADDR, 0);
    chk("rst_rdata", bus.mem_read_data, 0);
    chk("rst_dq_released", SRAM_DQ, 16'hA5A5);
    rst = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("idle_ready_noreq", bus.ready, 1);
      chk("idle_we_n", SRAM_WE_N, 1);
    end

    access(1, 0, 32'd1028, 32'hDEADBEEF, 18'd2, 32'h0);
    chk("sram_w_lo", sram[2], 16'hBEEF);
    chk("sram_w_hi", sram[3], 16'hDEAD);

    access(0, 1, 32'd1028, 32'h0, 18'd2, 32'hDEADBEEF);
    access(1, 0, 32'd1032, 32'h11112222, 18'd4, 32'hDEADBEEF);
    chk("rdata_after_write", bus.mem_read_data, 32'hDEADBEEF);

    access(1, 1, 32'd1024, 32'h12345678, 18'd0, 32'hDEADBEEF);
    chk("sram_rw_lo", sram[0], 16'h5678);
    chk("sram_rw_hi", sram[1], 16'h1234);
    access(0, 1, 32'd1024, 32'h0, 18'd0, 32'h12345678);

    access(1, 0, 32'd1020, 32'h0BADF00D, 18'h3FFFE, 32'h12345678);
    chk("sram_wrap_lo", sram[8'hFE], 16'hF00D);
    chk("sram_wrap_hi", sram[8'hFF], 16'h0BAD);
    access(0, 1, 32'd1020, 32'h0, 18'h3FFFE, 32'h0BADF00D);

    bus.MEM_W_en = 1'b1;
    bus.address  = 32'd1036;
    bus.Val_Rm   = 32'hAAAA5555;
    for (int i = 0; i < 3; i++) begin @(negedge clk); #1; end
    chk("high_addr_before_rst", SRAM_ADDR, 18'd7);
    chk("high_we_before_rst", SRAM_WE_N, 0);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("async_rst_we_n", SRAM_WE_N, 1);
    chk("async_rst_addr", SRAM_ADDR, 0);
    chk("async_rst_ready", bus.ready, 1);
    #1 rst = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_ready", bus.ready, 1);
    chk("post_rst_we_n", SRAM_WE_N, 1);
    chk("post_rst_dq", SRAM_DQ, 16'h5678);
    chk("post_rst_rdata", bus.mem_read_data, 0);
    access(0, 1, 32'd1028, 32'h0, 18'd2, 32'hDEADBEEF);

    access(0, 1, 32'd1040, 32'h0, 18'd8, 32'h11223344);
`ifdef SRAM_LAST_WORD_CACHE_EN
    bus.MEM_R_en = 1'b1;
    bus.address  = 32'd1040;
    #1;
    chk("hit_ready", bus.ready, 1);
    chk("hit_data", bus.mem_read_data, 32'h11223344);
    @(negedge clk); #1;
    chk("hit_no_access", SRAM_ADDR, 0);
    chk("hit_ready_hold", bus.ready, 1);
    idle_inputs();
    @(negedge clk); #1;
    access(1, 0, 32'd1040, 32'hCAFEF00D, 18'd8, 32'h11223344);
    bus.MEM_R_en = 1'b1;
    bus.address  = 32'd1040;
    #1;
    chk("hit_after_wr_ready", bus.ready, 1);
    chk("hit_after_wr_data", bus.mem_read_data, 32'hCAFEF00D);
    idle_inputs();
    @(negedge clk); #1;
`else
    access(0, 1, 32'd1040, 32'h0, 18'd8, 32'h11223344);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
